// File: rtl/inst_sequencer.sv
// Clocked multi-channel instruction sequencer: decodes SPI instruction strobes into
// fixed-width per-channel pulses and manages sampling-clock enables with a delayed trigger stop.
module inst_sequencer #(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned INST_W    = 3,
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned DLY_W     = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              inst_valid,
    input  logic [INST_W-1:0] inst_code,
    input  logic [NUM_CH-1:0] inst_mask,
    input  logic [DLY_W-1:0]  stop_delay,
    input  logic              inst_stop,
    output logic [NUM_CH-1:0] inst_rst,
    output logic [NUM_CH-1:0] inst_readout,
    output logic [NUM_CH-1:0] inst_start,
    output logic [NUM_CH-1:0] clk_enable,
    output logic              busy,
    output logic              inst_err
);

    localparam int unsigned PL_W = $clog2(PULSE_LEN + 1);

    localparam logic [INST_W-1:0] C_NOP     = INST_W'(0);
    localparam logic [INST_W-1:0] C_RESET   = INST_W'(1);
    localparam logic [INST_W-1:0] C_READOUT = INST_W'(2);
    localparam logic [INST_W-1:0] C_START   = INST_W'(3);
    localparam logic [INST_W-1:0] C_STOP    = INST_W'(4);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_PULSE = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [PL_W-1:0]   r_plen, w_plen_nxt;
    logic [INST_W-1:0] r_code, w_code_nxt;
    logic [NUM_CH-1:0] r_mask, w_mask_nxt;
    logic              w_acc, w_rej, w_busy_nxt;
    logic [NUM_CH-1:0] w_rst_nxt, w_rd_nxt, w_st_nxt;

    logic              r_sync1, r_sync2, r_sync3;
    logic              r_pend, w_pend_nxt;
    logic [DLY_W-1:0]  r_cnt, w_cnt_nxt;
    logic              w_edge, w_load, w_expire, w_start;
    logic [NUM_CH-1:0] w_set, w_clr, w_en_nxt;

    // Instruction decode, pulse timing and registered output values
    always_comb begin
        w_state_nxt = r_state;
        w_plen_nxt  = r_plen;
        w_code_nxt  = r_code;
        w_mask_nxt  = r_mask;
        w_acc       = 1'b0;
        w_rej       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (inst_valid && (inst_code != C_NOP)) begin
                    if ((inst_code > C_STOP) || (inst_mask == '0) ||
                        ((inst_code == C_READOUT) && (|(inst_mask & clk_enable)))) begin
                        w_rej = 1'b1;
                    end else begin
                        w_acc       = 1'b1;
                        w_state_nxt = S_PULSE;
                        w_plen_nxt  = PL_W'(PULSE_LEN - 1);
                        w_code_nxt  = inst_code;
                        w_mask_nxt  = inst_mask;
                    end
                end
            end
            S_PULSE: begin
                w_rej = inst_valid;
                if (r_plen == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_plen_nxt = r_plen - PL_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == S_PULSE);
        w_rst_nxt  = (w_busy_nxt && (w_code_nxt == C_RESET))   ? w_mask_nxt : '0;
        w_rd_nxt   = (w_busy_nxt && (w_code_nxt == C_READOUT)) ? w_mask_nxt : '0;
        w_st_nxt   = (w_busy_nxt && (w_code_nxt == C_START))   ? w_mask_nxt : '0;
    end

    // Trigger countdown and clock-enable update; START set wins over any clear
    always_comb begin
        w_edge     = r_sync2 & ~r_sync3;
        w_load     = w_edge && (|clk_enable) && !r_pend;
        w_expire   = (w_load && (stop_delay == '0)) || (r_pend && (r_cnt == DLY_W'(1)));
        w_start    = w_acc && (inst_code == C_START);
        w_pend_nxt = r_pend;
        w_cnt_nxt  = r_cnt;
        if (w_start) begin
            w_pend_nxt = 1'b0;
        end else if (r_pend) begin
            if (r_cnt == DLY_W'(1)) begin
                w_pend_nxt = 1'b0;
            end else begin
                w_cnt_nxt = r_cnt - DLY_W'(1);
            end
        end else if (w_load && (stop_delay != '0)) begin
            w_pend_nxt = 1'b1;
            w_cnt_nxt  = stop_delay;
        end
        w_set = w_start ? inst_mask : '0;
        if (w_expire) begin
            w_clr = '1;
        end else if (w_acc && ((inst_code == C_STOP) || (inst_code == C_RESET))) begin
            w_clr = inst_mask;
        end else begin
            w_clr = '0;
        end
        w_en_nxt = (clk_enable & ~w_clr) | w_set;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_plen       <= '0;
            r_code       <= '0;
            r_mask       <= '0;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync3      <= 1'b0;
            r_pend       <= 1'b0;
            r_cnt        <= '0;
            inst_rst     <= '0;
            inst_readout <= '0;
            inst_start   <= '0;
            clk_enable   <= '0;
            busy         <= 1'b0;
            inst_err     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_plen       <= w_plen_nxt;
            r_code       <= w_code_nxt;
            r_mask       <= w_mask_nxt;
            r_sync1      <= inst_stop;
            r_sync2      <= r_sync1;
            r_sync3      <= r_sync2;
            r_pend       <= w_pend_nxt;
            r_cnt        <= w_cnt_nxt;
            inst_rst     <= w_rst_nxt;
            inst_readout <= w_rd_nxt;
            inst_start   <= w_st_nxt;
            clk_enable   <= w_en_nxt;
            busy         <= w_busy_nxt;
            inst_err     <= w_rej;
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: timeline-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_inst_sequencer;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned INST_W = 3;
    localparam int unsigned PL     = 4;
    localparam int unsigned DLY_W  = 8;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              inst_valid = 1'b0;
    logic [INST_W-1:0] inst_code = '0;
    logic [NUM_CH-1:0] inst_mask = '0;
    logic [DLY_W-1:0]  stop_delay = '0;
    logic              inst_stop = 1'b0;
    logic [NUM_CH-1:0] inst_rst, inst_readout, inst_start, clk_enable;
    logic              busy, inst_err;

    int n_chk = 0;
    int n_fail = 0;

    inst_sequencer #(.NUM_CH(NUM_CH), .INST_W(INST_W), .PULSE_LEN(PL), .DLY_W(DLY_W)) dut (
        .clk(clk), .rstn(rstn), .inst_valid(inst_valid), .inst_code(inst_code),
        .inst_mask(inst_mask), .stop_delay(stop_delay), .inst_stop(inst_stop),
        .inst_rst(inst_rst), .inst_readout(inst_readout), .inst_start(inst_start),
        .clk_enable(clk_enable), .busy(busy), .inst_err(inst_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: absolute edge times of accepted instructions and trigger expiry
    int              cyc = 0;
    int              acc_t = -100;
    logic [2:0]      acc_code = '0;
    logic [7:0]      acc_mask = '0;
    bit              armed = 0;
    int              exp_at = 0;
    bit              prev_stop = 0;
    int              evq[$];
    logic [7:0]      m_en = '0, m_rst = '0, m_rd = '0, m_st = '0;
    logic            m_busy = 0, m_err = 0;

    always @(posedge clk or negedge rstn) begin
        bit rej, acc, expire, active, en_any;
        logic [7:0] set_m, clr_m;
        if (!rstn) begin
            acc_t = -100; armed = 0; prev_stop = 0; evq.delete();
            m_en = '0; m_rst = '0; m_rd = '0; m_st = '0; m_busy = 0; m_err = 0;
        end else begin
            cyc++;
            rej = 0; acc = 0; expire = 0;
            en_any = |m_en;
            if (inst_valid) begin
                if (cyc >= acc_t + 1 && cyc <= acc_t + int'(PL)) rej = 1;
                else if (inst_code == 0) acc = 0;
                else if (inst_code > 4 || inst_mask == 0) rej = 1;
                else if (inst_code == 2 && (inst_mask & m_en) != 0) rej = 1;
                else acc = 1;
            end
            if (acc) begin acc_t = cyc; acc_code = inst_code; acc_mask = inst_mask; end
            if (evq.size() > 0 && evq[0] == cyc) begin
                void'(evq.pop_front());
                if (en_any && !armed) begin armed = 1; exp_at = cyc + int'(stop_delay); end
            end
            if (armed && exp_at == cyc) begin expire = 1; armed = 0; end
            if (inst_stop && !prev_stop) evq.push_back(cyc + 2);
            prev_stop = inst_stop;
            set_m = (acc && inst_code == 3) ? inst_mask : 8'h00;
            if (acc && inst_code == 3) armed = 0;
            if (expire) clr_m = 8'hFF;
            else if (acc && (inst_code == 4 || inst_code == 1)) clr_m = inst_mask;
            else clr_m = 8'h00;
            m_en = (m_en & ~clr_m) | set_m;
            active = (acc_t <= cyc) && (cyc <= acc_t + int'(PL) - 1);
            m_rst  = (active && acc_code == 1) ? acc_mask : 8'h00;
            m_rd   = (active && acc_code == 2) ? acc_mask : 8'h00;
            m_st   = (active && acc_code == 3) ? acc_mask : 8'h00;
            m_busy = active;
            m_err  = rej;
        end
    end

    always @(negedge clk) begin
        chk("model_rst", 32'(inst_rst), 32'(m_rst));
        chk("model_readout", 32'(inst_readout), 32'(m_rd));
        chk("model_start", 32'(inst_start), 32'(m_st));
        chk("model_clk_enable", 32'(clk_enable), 32'(m_en));
        chk("model_busy", 32'(busy), 32'(m_busy));
        chk("model_err", 32'(inst_err), 32'(m_err));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Present an instruction for one edge; returns just after the following negedge
    task automatic send(input logic [2:0] code, input logic [7:0] mask);
        inst_valid = 1'b1;
        inst_code  = code;
        inst_mask  = mask;
        step();
        inst_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < int'(PL); i++) step();
    endtask

    initial begin
        int n;
        #1 rstn = 1'b0;
        step();
        chk("reset_outputs", 32'({inst_rst, inst_readout, inst_start, clk_enable, busy, inst_err}), 32'h0);
        step();
        rstn = 1'b1;

        // RESET 0x05 right after release: 4-cycle pulse with busy, no error
        send(3'd1, 8'h05);
        chk("reset_err", 32'(inst_err), 32'h0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (inst_rst == 8'h05 && busy) n++;
            step();
        end
        chk("reset_pulse_len", 32'(n), 32'd4);

        // START 0xFF, stop_delay 10, re-trigger during countdown must not restart it
        send(3'd3, 8'hFF);
        wait_idle();
        stop_delay = 8'd10;
        inst_stop = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            step();
            if (k == 2) inst_stop = 1'b0;
            if (k == 5) inst_stop = 1'b1;
            if (k == 11) chk("trig_before", 32'(clk_enable), 32'hFF);
            if (k == 12) chk("trig_after", 32'(clk_enable), 32'h00);
        end
        inst_stop = 1'b0;
        step(); step(); step();

        // READOUT blocked by enabled channel, allowed after STOP
        send(3'd3, 8'h0F);
        wait_idle();
        send(3'd2, 8'h01);
        chk("readout_rej_err", 32'(inst_err), 32'h1);
        chk("readout_rej_pulse", 32'(inst_readout), 32'h0);
        send(3'd4, 8'h0F);
        chk("stop_en", 32'(clk_enable), 32'h00);
        wait_idle();
        send(3'd2, 8'h01);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (inst_readout == 8'h01) n++;
            step();
        end
        chk("readout_pulse_len", 32'(n), 32'd4);

        // Busy window boundaries and malformed instructions
        send(3'd3, 8'h01);
        send(3'd1, 8'h01);
        chk("busy_rej_1", 32'(inst_err), 32'h1);
        step(); step();
        send(3'd1, 8'h01);
        chk("busy_rej_4", 32'(inst_err), 32'h1);
        send(3'd1, 8'h01);
        chk("accept_5_err", 32'(inst_err), 32'h0);
        chk("accept_5_rst", 32'(inst_rst), 32'h01);
        wait_idle();
        send(3'd6, 8'h01);
        chk("reserved_rej", 32'(inst_err), 32'h1);
        send(3'd3, 8'h00);
        chk("zero_mask_rej", 32'(inst_err), 32'h1);
        chk("zero_mask_busy", 32'(busy), 32'h0);
        step();

        // START one edge before countdown expiry cancels it
        send(3'd3, 8'h05);
        wait_idle();
        stop_delay = 8'd6;
        inst_stop = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            step();
            if (k == 2) inst_stop = 1'b0;
            if (k == 6) begin inst_valid = 1'b1; inst_code = 3'd3; inst_mask = 8'h02; end
            if (k == 7) begin inst_valid = 1'b0; chk("cancel_set", 32'(clk_enable), 32'h07); end
            if (k == 8) chk("cancel_expiry", 32'(clk_enable), 32'h07);
            if (k == 20) chk("cancel_late", 32'(clk_enable), 32'h07);
        end

        // Reset mid-pulse with a countdown pending
        stop_delay = 8'd20;
        inst_stop = 1'b1;
        step(); step(); step();
        inst_stop = 1'b0;
        step();
        send(3'd3, 8'h10);
        step();
        rstn = 1'b0;
        #1;
        chk("midrst_start", 32'(inst_start), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_en", 32'(clk_enable), 32'h0);
        step(); step();
        rstn = 1'b1;
        send(3'd3, 8'h08);
        chk("post_rst_start", 32'(inst_start), 32'h08);
        chk("post_rst_en", 32'(clk_enable), 32'h08);
        for (int i = 0; i < 40; i++) step();
        chk("no_stale_expiry", 32'(clk_enable), 32'h08);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_sequencer.md
# inst_sequencer

Clocked, multi-channel successor to the asynchronous instruction decoder. Accepts instruction strobes from the SPI register block, issues fixed-width reset/readout/start pulses to a selectable subset of sampling channels, and manages per-channel sampling-clock enables. Trigger-driven stops use a programmable post-trigger delay. Sits between the SPI register file and the channel array.

## Interface
- NUM_CH, 8, number of sampling channels (1..32)
- INST_W, 3, instruction code width (>= 3)
- PULSE_LEN, 4, command pulse width in clk cycles (>= 1)
- DLY_W, 8, width of post-trigger stop delay
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- inst_valid  in  1  one-cycle strobe: inst_code/inst_mask valid
- inst_code  in  INST_W  0 NOP, 1 RESET, 2 READOUT, 3 START, 4 STOP, others reserved
- inst_mask  in  NUM_CH  target channels for the instruction
- stop_delay  in  DLY_W  cycles between detected trigger and sampling stop; static while sampling
- inst_stop  in  1  trigger input, asynchronous to clk
- inst_rst  out  NUM_CH  per-channel reset pulse
- inst_readout  out  NUM_CH  per-channel readout pulse
- inst_start  out  NUM_CH  per-channel start pulse
- clk_enable  out  NUM_CH  per-channel sampling-clock enable (level)
- busy  out  1  pulse in progress; instructions rejected
- inst_err  out  1  one-cycle flag: instruction rejected

## Operation
- Reset (rstn low): all outputs 0 asynchronously. Control FSM to IDLE. Stop countdown cleared. Synchronizer cleared.
- Control FSM states:
  - IDLE: on inst_valid, decode. Accepted RESET/READOUT/START/STOP loads the target mask and moves to PULSE.
  - PULSE: the pulse output for the latched code drives the latched mask for PULSE_LEN cycles, then the FSM returns to IDLE.
- STOP has no pulse output. It clears clk_enable of masked channels and otherwise occupies PULSE like the other commands.
- NOP: accepted in IDLE. No pulse, no busy, no err.
- Rejection: inst_err pulses for one cycle and no state change occurs when any of these holds:
  - inst_valid arrives while busy;
  - the code is reserved;
  - inst_mask is 0 for a non-NOP code;
  - READOUT targets any channel whose clk_enable is 1.
- RESET clears clk_enable of masked channels when the pulse starts.
- START sets clk_enable of masked channels when the pulse starts and cancels any pending trigger countdown.
- Trigger path:
  - inst_stop passes through a 2-flop synchronizer, followed by rising-edge detect.
  - On a detected edge, if any clk_enable is 1 and no countdown is pending, the counter loads stop_delay.
  - When the countdown expires, all clk_enable bits clear.
  - Edges arriving while a countdown is pending are ignored.
  - Edges arriving while all clk_enable bits are 0 are ignored.
- Priority in one cycle: START set > countdown-expiry clear > STOP/RESET clear. A channel is never both set and cleared in the same cycle.

## Timing
- Instruction accepted at clk edge T, FSM in IDLE:
  - pulse outputs and busy are high from edge T+1 through edge T+PULSE_LEN, low after that edge;
  - clk_enable changes from START/STOP/RESET take effect at edge T+1.
- inst_valid sampled at edge T+PULSE_LEN is still rejected. Minimum accepted spacing is PULSE_LEN+1 cycles.
- inst_err is high for the one cycle following the rejecting edge.
- Trigger latency:
  - inst_stop is first sampled high at edge S;
  - clk_enable clears at edge S+2+stop_delay (stop_delay=0 gives S+2; maximum 2^DLY_W−1 gives S+2+2^DLY_W−1);
  - inst_stop must stay high for at least 2 clk cycles;
  - a new edge requires inst_stop low for at least 2 cycles.
- Reset asserted mid-pulse: pulses, busy and clk_enable drop immediately. After release the FSM is in IDLE and inst_valid is accepted on the first edge.

## Test plan
- NUM_CH=8, PULSE_LEN=4. At reset release, RESET is issued with mask 0x05: inst_rst=0x05 for exactly 4 cycles, busy high for the same 4 cycles, inst_err=0.
- START with mask 0xFF, stop_delay=10, then inst_stop is raised and first sampled at edge S: clk_enable=0xFF until edge S+11 and 0x00 from edge S+12. A second trigger during the countdown does not restart it.
- START with mask 0x0F, then READOUT with mask 0x01 once busy has dropped: inst_err pulses and inst_readout stays 0. STOP with mask 0x0F, then READOUT with mask 0x01: a 4-cycle pulse is issued.
- START with mask 0x01, then inst_valid with a new code 1 cycle and 4 cycles later: both are rejected with inst_err. inst_valid at 5 cycles is accepted. Reserved code 6 and zero mask are each rejected.
- Trigger countdown expiring at edge X, with a START (mask 0x02) accepted at edge X−1: clk_enable bit 1 stays 1, countdown is cancelled, other bits keep their prior value.
- rstn asserted at the 2nd cycle of a START pulse with a countdown pending: all outputs 0 immediately. After release, a new START is accepted on the first edge and no stale countdown fires.
